// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IM/DM memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

   // Arbiter sequencing: wait for a request, hold the bus, pulse completion.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   // Which port currently owns the bus access.
   typedef enum logic {
      OWN_IM = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   localparam int TIMEOUT_DEFAULT = 255;

   // Counter width able to hold the watchdog limit (at least one bit).
   function automatic int cnt_width(input int limit);
      return (limit < 2) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Sticky flag raised when an enabled run of cycles reaches the limit.
// Latency: flag rises on the edge that ends the limit-th enabled cycle.
// Backpressure: none; observes only, never stalls the access.
module bus_watchdog #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             flag
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;

   // Count stalled cycles, saturating at the limit; a zero limit disables it.
   always_comb begin
      cnt_d  = cnt_q;
      flag_d = flag_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (limit != '0) && (cnt_q != limit)) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == limit) begin
            flag_d = 1'b1;
         end
      end
   end

   // State registers; the flag is only cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign flag = flag_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding req/ack bus between fetch (IM) and data (DM) ports, DM first.
// Latency: request at t -> bus_req at t+1 -> valid pulse at t+2 with a zero-wait ack.
// Backpressure: ports hold their level request until valid; bus_req holds until bus_ack.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int memAddrWidth = 16,
   parameter int DataWidth    = 32,
   parameter int TIMEOUT      = TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    im_req,
   input  logic [memAddrWidth-1:0] im_addr,
   output logic [DataWidth-1:0]    im_rdata,
   output logic                    im_valid,
   input  logic                    dm_r,
   input  logic [3:0]              dm_w,
   input  logic [memAddrWidth-1:0] dm_addr,
   input  logic [DataWidth-1:0]    dm_wdata,
   output logic [DataWidth-1:0]    dm_rdata,
   output logic                    dm_valid,
   output logic                    bus_req,
   output logic [3:0]              bus_we,
   output logic [memAddrWidth-1:0] bus_addr,
   output logic [DataWidth-1:0]    bus_wdata,
   input  logic                    bus_ack,
   input  logic [DataWidth-1:0]    bus_rdata,
   output logic                    bus_err
);

   localparam int CNT_W = cnt_width(TIMEOUT);

   arb_state_t              state_q, state_d;
   owner_t                  owner_q, owner_d;
   logic                    bus_req_q, bus_req_d;
   logic [3:0]              bus_we_q, bus_we_d;
   logic [memAddrWidth-1:0] bus_addr_q, bus_addr_d;
   logic [DataWidth-1:0]    bus_wdata_q, bus_wdata_d;
   logic                    im_valid_q, im_valid_d;
   logic                    dm_valid_q, dm_valid_d;
   logic [DataWidth-1:0]    im_rdata_q, im_rdata_d;
   logic [DataWidth-1:0]    dm_rdata_q, dm_rdata_d;

   logic dm_req;
   logic grant;
   logic grant_dm;

   // A nonzero byte mask makes the DM access a write regardless of dm_r.
   assign dm_req = dm_r | (dm_w != 4'b0000);

   // Next-state, grant selection and bus/response register updates.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      im_valid_d  = 1'b0;
      dm_valid_d  = 1'b0;
      im_rdata_d  = im_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      grant       = 1'b0;
      grant_dm    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (dm_req) begin
               grant    = 1'b1;
               grant_dm = 1'b1;
            end else if (im_req) begin
               grant = 1'b1;
            end
         end
         ST_BUSY: begin
            if (bus_ack) begin
               bus_req_d = 1'b0;
               state_d   = ST_RESP;
               if (owner_q == OWN_DM) begin
                  dm_valid_d = 1'b1;
                  if (bus_we_q == 4'b0000) begin
                     dm_rdata_d = bus_rdata;
                  end
               end else begin
                  im_valid_d = 1'b1;
                  im_rdata_d = bus_rdata;
               end
            end
         end
         ST_RESP: begin
            // The owner still shows its request this cycle, so only the other port may win.
            state_d = ST_IDLE;
            if ((owner_q == OWN_IM) && dm_req) begin
               grant    = 1'b1;
               grant_dm = 1'b1;
            end else if ((owner_q == OWN_DM) && im_req) begin
               grant = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (grant) begin
         state_d   = ST_BUSY;
         bus_req_d = 1'b1;
         if (grant_dm) begin
            owner_d     = OWN_DM;
            bus_addr_d  = dm_addr;
            bus_wdata_d = dm_wdata;
            bus_we_d    = dm_w;
         end else begin
            owner_d     = OWN_IM;
            bus_addr_d  = im_addr;
            bus_wdata_d = '0;
            bus_we_d    = 4'b0000;
         end
      end
   end

   // Register all state; reset wins over any in-flight access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_IM;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 4'b0000;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         im_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
         im_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         im_valid_q  <= im_valid_d;
         dm_valid_q  <= dm_valid_d;
         im_rdata_q  <= im_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   bus_watchdog #(
      .CNT_W (CNT_W)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (grant),
      .enable ((state_q == ST_BUSY) && !bus_ack),
      .limit  (CNT_W'(TIMEOUT)),
      .flag   (bus_err)
   );

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign im_valid  = im_valid_q;
   assign dm_valid  = dm_valid_q;
   assign im_rdata  = im_rdata_q;
   assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small programmable bus responder.
// Latency: n/a.
// Backpressure: responder delays bus_ack by ack_wait cycles or withholds it.
module tb_mem_port_arbiter;

   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          im_req;
   logic [AW-1:0] im_addr;
   logic [DW-1:0] im_rdata;
   logic          im_valid;
   logic          dm_r;
   logic [3:0]    dm_w;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_valid;
   logic          bus_req;
   logic [3:0]    bus_we;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata;
   logic          bus_ack;
   logic [DW-1:0] bus_rdata;
   logic          bus_err;

   mem_port_arbiter #(
      .memAddrWidth (AW),
      .DataWidth    (DW),
      .TIMEOUT      (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .im_req    (im_req),
      .im_addr   (im_addr),
      .im_rdata  (im_rdata),
      .im_valid  (im_valid),
      .dm_r      (dm_r),
      .dm_w      (dm_w),
      .dm_addr   (dm_addr),
      .dm_wdata  (dm_wdata),
      .dm_rdata  (dm_rdata),
      .dm_valid  (dm_valid),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int overlap_cnt = 0;
   int im_vcnt = 0;
   int dm_vcnt = 0;
   int breq_cnt = 0;
   int st_stable = 0;
   int wait_cnt = 0;
   int ack_wait = 0;
   bit resp_en = 1'b1;
   logic [DW-1:0] resp_data = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock: sample DUT outputs 1ns after the edge, then run the bus responder.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (im_valid && dm_valid) overlap_cnt++;
      if (im_valid) im_vcnt++;
      if (dm_valid) dm_vcnt++;
      if (bus_req) breq_cnt++;
      if (bus_req && bus_we == 4'b0001 && bus_addr == 16'h0100 && bus_wdata == 32'hAABBCCDD)
         st_stable++;
      if (bus_ack) begin
         bus_ack = 1'b0;
      end else if (resp_en && bus_req) begin
         if (wait_cnt >= ack_wait) begin
            bus_ack   = 1'b1;
            bus_rdata = resp_data;
            wait_cnt  = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
   endtask

   // Tick until the selected valid is seen; reports the cycle it appeared or -1.
   task automatic wait_valid(input bit is_dm, input int max, input string tag, output int at);
      at = -1;
      for (int i = 0; i < max; i++) begin
         tick();
         if (is_dm ? dm_valid : im_valid) begin
            at = cyc;
            break;
         end
      end
      chk(tag, 32'(at >= 0), 32'd1);
   endtask

   initial begin
      int t0;
      int at;
      int at_dm;
      int at_im;
      int err_early;

      rst       = 1'b1;
      im_req    = 1'b0;
      im_addr   = '0;
      dm_r      = 1'b0;
      dm_w      = 4'b0000;
      dm_addr   = '0;
      dm_wdata  = '0;
      bus_ack   = 1'b0;
      bus_rdata = '0;

      tick();
      tick();
      chk("rst_bus_req",  32'(bus_req),  32'd0);
      chk("rst_bus_err",  32'(bus_err),  32'd0);
      chk("rst_valids",   32'({im_valid, dm_valid}), 32'd0);
      chk("rst_bus_addr", 32'(bus_addr), 32'd0);
      chk("rst_bus_we",   32'(bus_we),   32'd0);
      chk("rst_im_rdata", im_rdata,      32'd0);
      chk("rst_dm_rdata", dm_rdata,      32'd0);
      rst = 1'b0;
      tick();

      // Zero-wait instruction fetch.
      breq_cnt  = 0;
      resp_data = 32'h0000_0013;
      im_req    = 1'b1;
      im_addr   = 16'h0040;
      t0        = cyc;
      tick();
      chk("t1_bus_req",  32'(bus_req),  32'd1);
      chk("t1_bus_addr", 32'(bus_addr), 32'h0040);
      chk("t1_bus_we",   32'(bus_we),   32'd0);
      wait_valid(1'b0, 10, "t1_im_valid_seen", at);
      chk("t1_latency",  32'(at - t0),  32'd2);
      chk("t1_im_rdata", im_rdata,      32'h0000_0013);
      im_req = 1'b0;
      tick();
      tick();
      chk("t1_breq_cycles", 32'(breq_cnt), 32'd1);

      // Simultaneous requests: DM first, IM granted straight from RESP.
      resp_data = 32'h1111_1111;
      dm_r      = 1'b1;
      dm_addr   = 16'h0200;
      im_req    = 1'b1;
      im_addr   = 16'h0080;
      tick();
      chk("t2_dm_first_addr", 32'(bus_addr), 32'h0200);
      wait_valid(1'b1, 10, "t2_dm_valid_seen", at_dm);
      chk("t2_dm_rdata",    dm_rdata,         32'h1111_1111);
      chk("t2_im_quiet",    32'(im_valid),    32'd0);
      dm_r      = 1'b0;
      resp_data = 32'h2222_2222;
      tick();
      chk("t2_im_grant_addr", 32'(bus_addr), 32'h0080);
      wait_valid(1'b0, 10, "t2_im_valid_seen", at_im);
      chk("t2_im_after_dm", 32'(at_im - at_dm), 32'd2);
      chk("t2_im_rdata",    im_rdata,           32'h2222_2222);
      im_req = 1'b0;
      tick();

      // Byte store with a 3-cycle ack delay; inputs wiggle mid-access.
      dm_vcnt   = 0;
      breq_cnt  = 0;
      st_stable = 0;
      ack_wait  = 3;
      resp_data = 32'hDEAD_BEEF;
      dm_w      = 4'b0001;
      dm_addr   = 16'h0100;
      dm_wdata  = 32'hAABB_CCDD;
      tick();
      dm_addr  = 16'h0FFF;
      dm_wdata = 32'h0000_0000;
      wait_valid(1'b1, 20, "t3_dm_valid_seen", at);
      dm_w = 4'b0000;
      tick();
      tick();
      chk("t3_stable_cycles", 32'(st_stable), 32'd4);
      chk("t3_breq_cycles",   32'(breq_cnt),  32'd4);
      chk("t3_dm_pulses",     32'(dm_vcnt),   32'd1);
      chk("t3_dm_rdata_kept", dm_rdata,       32'h1111_1111);
      ack_wait = 0;

      // IM request held through its valid cycle: no re-grant from RESP.
      im_vcnt   = 0;
      resp_data = 32'h0000_0005;
      im_req    = 1'b1;
      im_addr   = 16'h0060;
      wait_valid(1'b0, 10, "t4_im_valid_seen", at);
      tick();
      chk("t4_no_grant_in_resp", 32'(bus_req), 32'd0);
      tick();
      chk("t4_regrant_from_idle", 32'(bus_req), 32'd1);
      wait_valid(1'b0, 10, "t4_second_valid_seen", at);
      im_req = 1'b0;
      tick();
      tick();
      chk("t4_im_pulses", 32'(im_vcnt), 32'd2);

      // Watchdog with the ack withheld.
      resp_en   = 1'b0;
      err_early = 0;
      im_req    = 1'b1;
      im_addr   = 16'h0070;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus_err) err_early++;
      end
      chk("t5_err_before_limit", 32'(err_early), 32'd0);
      chk("t5_breq_held",        32'(bus_req),   32'd1);
      tick();
      chk("t5_err_set", 32'(bus_err), 32'd1);
      repeat (3) tick();
      chk("t5_err_sticky", 32'(bus_err), 32'd1);
      resp_en   = 1'b1;
      resp_data = 32'h0000_0077;
      wait_valid(1'b0, 10, "t5_late_valid_seen", at);
      chk("t5_im_rdata", im_rdata, 32'h0000_0077);
      im_req = 1'b0;
      tick();
      chk("t5_err_after_done", 32'(bus_err), 32'd1);

      // Reset in the middle of a DM write, then a stray ack.
      resp_en  = 1'b0;
      dm_w     = 4'b1111;
      dm_addr  = 16'h0300;
      dm_wdata = 32'h1234_5678;
      tick();
      tick();
      chk("t6_busy", 32'(bus_req), 32'd1);
      rst  = 1'b1;
      dm_w = 4'b0000;
      tick();
      rst = 1'b0;
      chk("t6_bus_req",   32'(bus_req),   32'd0);
      chk("t6_bus_we",    32'(bus_we),    32'd0);
      chk("t6_bus_addr",  32'(bus_addr),  32'd0);
      chk("t6_bus_wdata", bus_wdata,      32'd0);
      chk("t6_bus_err",   32'(bus_err),   32'd0);
      chk("t6_im_rdata",  im_rdata,       32'd0);
      chk("t6_dm_rdata",  dm_rdata,       32'd0);
      dm_vcnt = 0;
      im_vcnt = 0;
      bus_ack = 1'b1;
      tick();
      tick();
      tick();
      chk("t6_stray_ack_valids", 32'(dm_vcnt + im_vcnt), 32'd0);
      chk("t6_stray_ack_breq",   32'(bus_req),           32'd0);

      chk("no_dual_valid", 32'(overlap_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
